// File: rtl/ps2_scancode_rx_pkg.sv
// Shared PS/2 receiver definitions: FSM state encoding, prefix bytes,
// frame length, and the colour make codes used by the colour-select stage.
package ps2_scancode_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_DECODE = 3'd4
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;

  localparam logic [7:0] COL_R = 8'h2D;
  localparam logic [7:0] COL_G = 8'h34;
  localparam logic [7:0] COL_B = 8'h32;
  localparam logic [7:0] COL_W = 8'h1D;

  // Odd parity holds when the data byte plus the parity bit has an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_scancode_rx_edge_filter.sv
// Input conditioning for the PS/2 pins: 2-FF synchronisers on clock and
// data, a FILTER_LEN-sample glitch filter on the clock, and a one-cycle
// pulse on each filtered 1->0 transition of the clock.
module ps2_scancode_rx_edge_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic data_s_o,
  output logic fall_o
);

  localparam int             CW         = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0]  CNT_RELOAD = CW'(FILTER_LEN - 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fall_q, fall_d;

  // Two-stage synchronisers; idle bus level is high on both pins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
    end
  end

  // Down-counter runs while the synchronised clock disagrees with the filtered
  // level; the level only flips on the FILTER_LEN-th consecutive disagreeing sample.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = CNT_RELOAD;
    if (clk_sync_q[1] != filt_q) begin
      if (cnt_q == '0) begin
        filt_d = clk_sync_q[1];
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  // Filter state and registered fall pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_q <= 1'b1;
      cnt_q  <= CNT_RELOAD;
      fall_q <= 1'b0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      fall_q <= fall_d;
    end
  end

  assign data_s_o = data_sync_q[1];
  assign fall_o   = fall_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard scancode receiver. Assembles 11-bit frames, strips F0
// (break) and E0 (extended) prefixes and presents each make code with a
// one-cycle valid strobe. Build option: PS2_PARITY_CHECK_EN enables odd
// parity checking; without it the parity bit is sampled and discarded.
//
//  state     | meaning
//  ----------+--------------------------------------------------------
//  ST_IDLE   | waiting for a start bit (fall with data low)
//  ST_DATA   | shifting in 8 data bits, LSB first
//  ST_PARITY | sampling the parity bit
//  ST_STOP   | checking stop bit (and parity); result registered here
//  ST_DECODE | one cycle in which the registered result is presented
module ps2_scancode_rx
  import ps2_scancode_rx_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       Pixelclock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scancode,
  output logic       scancode_valid,
  output logic       scancode_ext,
  output logic       frame_err
);

  localparam int            TW         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_RELOAD = TW'(TIMEOUT_CYC - 1);

  logic       data_s;
  logic       fall;

  ps2_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0] code_q, code_d;
  logic       code_ext_q, code_ext_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       par_ok;
  logic       active;
  logic       timeout;

`ifdef PS2_PARITY_CHECK_EN
  logic       par_q, par_d;
`endif

  ps2_scancode_rx_edge_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_edge_filter (
    .clk_i      (Pixelclock),
    .rst_i      (reset),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_data),
    .data_s_o   (data_s),
    .fall_o     (fall)
  );

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = odd_parity_ok(shift_q, par_q);
`else
  assign par_ok = 1'b1;
`endif

  assign active  = (state_q == ST_DATA) || (state_q == ST_PARITY) || (state_q == ST_STOP);
  // A fall in the same cycle as terminal count takes priority over the abort.
  assign timeout = active && !fall && (tmo_q == '0);

  // Next-state, datapath and output decode. The decode result is registered on
  // the stop-bit fall so scancode and its strobe appear together one cycle later.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    brk_d      = brk_q;
    ext_d      = ext_q;
    tmo_d      = tmo_q;
    code_d     = code_q;
    code_ext_d = code_ext_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d      = par_q;
`endif

    if ((state_q == ST_IDLE) || fall) begin
      tmo_d = TMO_RELOAD;
    end else if (tmo_q != '0) begin
      tmo_d = tmo_q - 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (fall && !data_s) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_d = {data_s, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            state_d   = ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
          par_d   = data_s;
`endif
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          if (data_s && par_ok) begin
            state_d = ST_DECODE;
            if (shift_q == PS2_BREAK) begin
              brk_d = 1'b1;
            end else if (shift_q == PS2_EXT) begin
              ext_d = 1'b1;
            end else if (brk_q) begin
              brk_d = 1'b0;
              ext_d = 1'b0;
            end else begin
              code_d     = shift_q;
              code_ext_d = ext_q;
              valid_d    = 1'b1;
              ext_d      = 1'b0;
            end
          end else begin
            err_d   = 1'b1;
            brk_d   = 1'b0;
            ext_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (timeout) begin
      err_d     = 1'b1;
      bit_cnt_d = '0;
      shift_d   = '0;
      brk_d     = 1'b0;
      ext_d     = 1'b0;
      state_d   = ST_IDLE;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      tmo_q      <= TMO_RELOAD;
      code_q     <= 8'h00;
      code_ext_q <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      tmo_q      <= tmo_d;
      code_q     <= code_d;
      code_ext_q <= code_ext_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q      <= par_d;
`endif
    end
  end

  assign scancode       = code_q;
  assign scancode_valid = valid_q;
  assign scancode_ext   = code_ext_q;
  assign frame_err      = err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: whole and partial PS/2 frames driven
// on the raw pins, prefix stripping, parity, timeout, glitch and reset.
// Shortened bit period and timeout keep the run small.
`timescale 1ns/1ps
module tb_ps2_scancode_rx;
  import ps2_scancode_rx_pkg::*;

  localparam int FL  = 8;
  localparam int TMO = 400;
  localparam int H   = 20;

  logic       Pixelclock = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scancode;
  logic       scancode_valid;
  logic       scancode_ext;
  logic       frame_err;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int wide_cnt = 0;
  int last_valid_cyc = 0;
  int stop_fall_cyc = 0;
  logic prev_valid = 1'b0;
  logic prev_err = 1'b0;
  int v0, e0;

  always #20 Pixelclock = ~Pixelclock;

  ps2_scancode_rx #(
    .FILTER_LEN  (FL),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .Pixelclock     (Pixelclock),
    .reset          (reset),
    .ps2_clk        (ps2_clk),
    .ps2_data       (ps2_data),
    .scancode       (scancode),
    .scancode_valid (scancode_valid),
    .scancode_ext   (scancode_ext),
    .frame_err      (frame_err)
  );

  // cycle counter for latency measurement
  always @(posedge Pixelclock) cyc <= cyc + 1;

  // pulse monitor, sampled away from the active edge
  always @(negedge Pixelclock) begin
    if (scancode_valid) begin
      valid_cnt      <= valid_cnt + 1;
      last_valid_cyc <= cyc;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
    if ((scancode_valid && prev_valid) || (frame_err && prev_err)) wide_cnt <= wide_cnt + 1;
    prev_valid <= scancode_valid;
    prev_err   <= frame_err;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge Pixelclock);
  endtask

  task automatic send_bits(input logic [10:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      ps2_data = f[i];
      wait_cyc(H);
      ps2_clk = 1'b0;
      if (i == PS2_FRAME_BITS - 1) stop_fall_cyc = cyc;
      wait_cyc(H);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bits(mk_frame(b, bad_par), 0, PS2_FRAME_BITS - 1);
    ps2_data = 1'b1;
    wait_cyc(4 * H);
  endtask

  initial begin
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    check_eq("rst_scancode", 32'(scancode), 32'h00);
    check_eq("rst_valid", 32'(scancode_valid), 32'h0);
    check_eq("rst_ext", 32'(scancode_ext), 32'h0);
    check_eq("rst_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    wait_cyc(10);

    // 1: plain make code
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(COL_R, 1'b0);
    check_eq("t1_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check_eq("t1_scancode", 32'(scancode), 32'h2D);
    check_eq("t1_ext", 32'(scancode_ext), 32'h0);
    check_eq("t1_err_cnt", 32'(err_cnt - e0), 32'd0);
    check_eq("t1_latency", 32'(last_valid_cyc - stop_fall_cyc), 32'(FL + 3));

    // 2: break sequence suppressed, following make accepted
    v0 = valid_cnt;
    send_frame(PS2_BREAK, 1'b0);
    check_eq("t2_f0_valid", 32'(valid_cnt - v0), 32'd0);
    send_frame(COL_R, 1'b0);
    check_eq("t2_brk_valid", 32'(valid_cnt - v0), 32'd0);
    send_frame(COL_G, 1'b0);
    check_eq("t2_make_valid", 32'(valid_cnt - v0), 32'd1);
    check_eq("t2_scancode", 32'(scancode), 32'h34);

    // 3: extended prefix
    v0 = valid_cnt;
    send_frame(PS2_EXT, 1'b0);
    check_eq("t3_e0_valid", 32'(valid_cnt - v0), 32'd0);
    send_frame(8'h75, 1'b0);
    check_eq("t3_ext_valid", 32'(valid_cnt - v0), 32'd1);
    check_eq("t3_scancode", 32'(scancode), 32'h75);
    check_eq("t3_ext", 32'(scancode_ext), 32'h1);
    send_frame(COL_W, 1'b0);
    check_eq("t3_next_scancode", 32'(scancode), 32'h1D);
    check_eq("t3_next_ext", 32'(scancode_ext), 32'h0);

    // 4: wrong parity bit
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(COL_B, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    check_eq("t4_err_cnt", 32'(err_cnt - e0), 32'd1);
    check_eq("t4_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    check_eq("t4_scancode", 32'(scancode), 32'h1D);
`else
    check_eq("t4_err_cnt", 32'(err_cnt - e0), 32'd0);
    check_eq("t4_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check_eq("t4_scancode", 32'(scancode), 32'h32);
`endif

    // long but sub-timeout gap inside a frame is tolerated
    v0 = valid_cnt; e0 = err_cnt;
    send_bits(mk_frame(COL_G, 1'b0), 0, 3);
    wait_cyc(TMO - 2 * H - 40);
    send_bits(mk_frame(COL_G, 1'b0), 4, PS2_FRAME_BITS - 1);
    ps2_data = 1'b1;
    wait_cyc(4 * H);
    check_eq("gap_err_cnt", 32'(err_cnt - e0), 32'd0);
    check_eq("gap_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check_eq("gap_scancode", 32'(scancode), 32'h34);

    // 5: partial frame times out, next frame decodes
    v0 = valid_cnt; e0 = err_cnt;
    send_bits(mk_frame(COL_W, 1'b0), 0, 4);
    ps2_data = 1'b1;
    wait_cyc(TMO + 100);
    check_eq("t5_err_cnt", 32'(err_cnt - e0), 32'd1);
    check_eq("t5_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    send_frame(COL_W, 1'b0);
    check_eq("t5_scancode", 32'(scancode), 32'h1D);
    check_eq("t5_valid_after", 32'(valid_cnt - v0), 32'd1);

    // 6a: short clock glitch with data low must not start a frame
    v0 = valid_cnt; e0 = err_cnt;
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    wait_cyc(FL - 1);
    ps2_clk  = 1'b1;
    wait_cyc(4);
    ps2_data = 1'b1;
    wait_cyc(4 * H);
    check_eq("t6_glitch_valid", 32'(valid_cnt - v0), 32'd0);
    send_frame(COL_R, 1'b0);
    check_eq("t6_glitch_scancode", 32'(scancode), 32'h2D);
    check_eq("t6_glitch_err", 32'(err_cnt - e0), 32'd0);

    // 6b: reset mid-frame
    send_bits(mk_frame(COL_G, 1'b0), 0, 5);
    reset = 1'b1;
    wait_cyc(3);
    check_eq("t6_rst_scancode", 32'(scancode), 32'h00);
    check_eq("t6_rst_ext", 32'(scancode_ext), 32'h0);
    check_eq("t6_rst_valid", 32'(scancode_valid), 32'h0);
    check_eq("t6_rst_err", 32'(frame_err), 32'h0);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(4 * H);
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(COL_R, 1'b0);
    check_eq("t6_post_scancode", 32'(scancode), 32'h2D);
    check_eq("t6_post_valid", 32'(valid_cnt - v0), 32'd1);
    check_eq("t6_post_err", 32'(err_cnt - e0), 32'd0);

    check_eq("pulse_width", 32'(wide_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
